// File: rtl/conv_pkg.sv
// Shared definitions for the convolution window scheduler.
//   state_t  : scheduler FSM encoding (IDLE, FETCH, WAIT, WRITE, DONE)
//   out_dim  : output feature-map side for a given image side, kernel and stride
//   taps     : number of taps in a KxK window
//   cnt_w    : counter width able to hold 0..bound-1 (never narrower than 1 bit)
package conv_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    WAIT  = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_t;

  function automatic int out_dim(input int img, input int k, input int stride);
    return (img - k) / stride + 1;
  endfunction

  function automatic int taps(input int k);
    return k * k;
  endfunction

  // A bound of 1 still needs a 1-bit counter; $clog2(1) would give 0.
  function automatic int cnt_w(input int bound);
    return (bound <= 1) ? 1 : $clog2(bound);
  endfunction

endpackage

// File: rtl/window_addr_gen.sv
// Tap counter and incremental read-address generator for one KxK window.
//   clk, rst     : clock and synchronous active-high reset
//   i_start      : load a new window origin from i_base, clear kr/kc
//   i_step       : advance to the next tap (held once the last tap is reached)
//   i_base       : window origin address (top-left pixel)
//   o_addr       : address of the current tap
//   o_first_tap  : current tap is (0,0)
//   o_last_tap   : current tap is (K-1,K-1)
module window_addr_gen
  import conv_pkg::*;
#(
  parameter int IMG_W  = 28,
  parameter int K      = 3,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic              i_step,
  input  logic [ADDR_W-1:0] i_base,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_first_tap,
  output logic              o_last_tap
);

  localparam int KW = cnt_w(K);
  localparam logic [KW-1:0]     K_MAX    = KW'(K - 1);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(IMG_W);

  logic [KW-1:0]     r_kr;
  logic [KW-1:0]     r_kc;
  logic [ADDR_W-1:0] r_row_start;
  logic [ADDR_W-1:0] r_addr;
  logic              w_kc_wrap;

  assign w_kc_wrap   = (r_kc == K_MAX);
  assign o_first_tap = (r_kr == '0) && (r_kc == '0);
  assign o_last_tap  = (r_kr == K_MAX) && w_kc_wrap;
  assign o_addr      = r_addr;

  // Address is built by addition only: +1 along a kernel row, and the
  // remembered row start plus one image line when the kernel row wraps.
  // Stepping past the last tap is suppressed so the address never leaves
  // the window (and therefore never leaves the image).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_kr        <= '0;
      r_kc        <= '0;
      r_row_start <= '0;
      r_addr      <= '0;
    end else if (i_start) begin
      r_kr        <= '0;
      r_kc        <= '0;
      r_row_start <= i_base;
      r_addr      <= i_base;
    end else if (i_step && !o_last_tap) begin
      if (w_kc_wrap) begin
        r_kc        <= '0;
        r_kr        <= r_kr + 1'b1;
        r_row_start <= r_row_start + ROW_STEP;
        r_addr      <= r_row_start + ROW_STEP;
      end else begin
        r_kc        <= r_kc + 1'b1;
        r_addr      <= r_addr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/conv_window_scheduler.sv
// Convolution window scheduler: sweeps a KxK window over one feature-map
// channel, issues tap reads, strobes the MAC and writes each patch result.
//   clk, rst   : clock and synchronous active-high reset
//   conv_en    : CONV phase level from the layer controller
//   rd_en      : input memory read strobe (one tap per cycle)
//   rd_addr    : input pixel address
//   mac_valid  : tap data valid at the MAC (rd_en delayed one cycle)
//   mac_first  : first tap of a patch (MAC clears accumulator)
//   mac_last   : last tap of a patch
//   res_valid  : MAC patch result ready (only looked at while waiting)
//   wr_en      : output write request, held until wr_ready
//   wr_addr    : output position index row*OUT_W+col
//   wr_ready   : output memory accepts the write
//   conv_done  : sweep complete, held until conv_en drops
//   busy       : scheduler not idle
module conv_window_scheduler
  import conv_pkg::*;
#(
  parameter int IMG_W   = 28,
  parameter int IMG_H   = 28,
  parameter int K       = 3,
  parameter int STRIDE  = 1,
  parameter int ADDR_W  = 10,
  parameter int OADDR_W = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               conv_en,
  output logic               rd_en,
  output logic [ADDR_W-1:0]  rd_addr,
  output logic               mac_valid,
  output logic               mac_first,
  output logic               mac_last,
  input  logic               res_valid,
  output logic               wr_en,
  output logic [OADDR_W-1:0] wr_addr,
  input  logic               wr_ready,
  output logic               conv_done,
  output logic               busy
);

  localparam int OUT_W = out_dim(IMG_W, K, STRIDE);
  localparam int OUT_H = out_dim(IMG_H, K, STRIDE);
  localparam int CW    = cnt_w(OUT_W);
  localparam int RW    = cnt_w(OUT_H);

  localparam logic [CW-1:0]     COL_MAX       = CW'(OUT_W - 1);
  localparam logic [RW-1:0]     ROW_MAX       = RW'(OUT_H - 1);
  localparam logic [ADDR_W-1:0] BASE_COL_STEP = ADDR_W'(STRIDE);
  localparam logic [ADDR_W-1:0] BASE_ROW_STEP = ADDR_W'(STRIDE * IMG_W);

  state_t              r_state;
  state_t              w_next;

  logic [RW-1:0]       r_out_row;
  logic [CW-1:0]       r_out_col;
  logic [OADDR_W-1:0]  r_oaddr;
  logic [ADDR_W-1:0]   r_base;
  logic [ADDR_W-1:0]   r_row_base;

  logic                r_mac_valid_p1;
  logic                r_mac_first_p1;
  logic                r_mac_last_p1;

  logic                w_first_tap;
  logic                w_last_tap;
  logic                w_launch;
  logic                w_last_pos;
  logic                w_advance;
  logic                w_row_wrap;
  logic [ADDR_W-1:0]   w_next_base;
  logic                w_ag_start;
  logic [ADDR_W-1:0]   w_ag_base;

  assign w_launch    = (r_state == IDLE) && conv_en;
  assign w_last_pos  = (r_out_row == ROW_MAX) && (r_out_col == COL_MAX);
  assign w_advance   = (r_state == WRITE) && wr_ready && !w_last_pos;
  assign w_row_wrap  = (r_out_col == COL_MAX);
  assign w_next_base = w_row_wrap ? (r_row_base + BASE_ROW_STEP)
                                  : (r_base + BASE_COL_STEP);

  // The address generator is loaded in the same edge that enters FETCH, so
  // the first tap address is already valid on the first FETCH cycle.
  assign w_ag_start  = w_launch || w_advance;
  assign w_ag_base   = w_launch ? '0 : w_next_base;

  window_addr_gen #(
    .IMG_W  (IMG_W),
    .K      (K),
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk         (clk),
    .rst         (rst),
    .i_start     (w_ag_start),
    .i_step      (rd_en),
    .i_base      (w_ag_base),
    .o_addr      (rd_addr),
    .o_first_tap (w_first_tap),
    .o_last_tap  (w_last_tap)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // res_valid only matters in WAIT; conv_en only in IDLE and DONE, so a
  // drop mid-sweep lets the sweep finish and DONE then lasts one cycle.
  always_comb begin
    w_next    = r_state;
    rd_en     = 1'b0;
    wr_en     = 1'b0;
    conv_done = 1'b0;
    busy      = 1'b1;
    case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (conv_en) w_next = FETCH;
      end
      FETCH: begin
        rd_en = 1'b1;
        if (w_last_tap) w_next = WAIT;
      end
      WAIT: begin
        if (res_valid) w_next = WRITE;
      end
      WRITE: begin
        wr_en = 1'b1;
        if (wr_ready) w_next = w_last_pos ? DONE : FETCH;
      end
      DONE: begin
        conv_done = 1'b1;
        if (!conv_en) w_next = IDLE;
      end
      default: begin
        busy   = 1'b0;
        w_next = IDLE;
      end
    endcase
  end

  // Output position, write index and window origin; all advance on the
  // accepted write, so wr_addr stays stable through a wr_ready stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_row  <= '0;
      r_out_col  <= '0;
      r_oaddr    <= '0;
      r_base     <= '0;
      r_row_base <= '0;
    end else if (w_launch) begin
      r_out_row  <= '0;
      r_out_col  <= '0;
      r_oaddr    <= '0;
      r_base     <= '0;
      r_row_base <= '0;
    end else if (w_advance) begin
      r_oaddr <= r_oaddr + 1'b1;
      r_base  <= w_next_base;
      if (w_row_wrap) begin
        r_out_col  <= '0;
        r_out_row  <= r_out_row + 1'b1;
        r_row_base <= w_next_base;
      end else begin
        r_out_col  <= r_out_col + 1'b1;
      end
    end
  end

  // ---- stage p1: tap data returns one cycle after the read strobe ----
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mac_valid_p1 <= 1'b0;
      r_mac_first_p1 <= 1'b0;
      r_mac_last_p1  <= 1'b0;
    end else begin
      r_mac_valid_p1 <= rd_en;
      r_mac_first_p1 <= rd_en && w_first_tap;
      r_mac_last_p1  <= rd_en && w_last_tap;
    end
  end

  assign mac_valid = r_mac_valid_p1;
  assign mac_first = r_mac_first_p1;
  assign mac_last  = r_mac_last_p1;
  assign wr_addr   = r_oaddr;

endmodule

// File: tb/tb_conv_window_scheduler.sv
// Directed bench for conv_window_scheduler on a 5x5 image with a 3x3 kernel,
// one instance at stride 1 and one at stride 2, selected by sel.
module tb_conv_window_scheduler;

  localparam int IMG = 5;
  localparam int KK  = 3;
  localparam int AW  = 10;
  localparam int OAW = 10;

  logic clk = 1'b0;
  logic rst, conv_en, res_valid, wr_ready, sel;
  always #5 clk = ~clk;

  logic en1, en2;
  assign en1 = conv_en & ~sel;
  assign en2 = conv_en & sel;

  logic           rd_en1, rd_en2, mv1, mv2, mf1, mf2, ml1, ml2;
  logic           we1, we2, cd1, cd2, bz1, bz2;
  logic [AW-1:0]  ra1, ra2;
  logic [OAW-1:0] wa1, wa2;

  conv_window_scheduler #(.IMG_W(IMG), .IMG_H(IMG), .K(KK), .STRIDE(1),
                          .ADDR_W(AW), .OADDR_W(OAW)) dut1 (
    .clk(clk), .rst(rst), .conv_en(en1), .rd_en(rd_en1), .rd_addr(ra1),
    .mac_valid(mv1), .mac_first(mf1), .mac_last(ml1), .res_valid(res_valid),
    .wr_en(we1), .wr_addr(wa1), .wr_ready(wr_ready), .conv_done(cd1), .busy(bz1));

  conv_window_scheduler #(.IMG_W(IMG), .IMG_H(IMG), .K(KK), .STRIDE(2),
                          .ADDR_W(AW), .OADDR_W(OAW)) dut2 (
    .clk(clk), .rst(rst), .conv_en(en2), .rd_en(rd_en2), .rd_addr(ra2),
    .mac_valid(mv2), .mac_first(mf2), .mac_last(ml2), .res_valid(res_valid),
    .wr_en(we2), .wr_addr(wa2), .wr_ready(wr_ready), .conv_done(cd2), .busy(bz2));

  logic           m_rd_en, m_mac_valid, m_mac_first, m_mac_last;
  logic           m_wr_en, m_conv_done, m_busy;
  logic [AW-1:0]  m_rd_addr;
  logic [OAW-1:0] m_wr_addr;
  assign m_rd_en     = sel ? rd_en2 : rd_en1;
  assign m_rd_addr   = sel ? ra2 : ra1;
  assign m_mac_valid = sel ? mv2 : mv1;
  assign m_mac_first = sel ? mf2 : mf1;
  assign m_mac_last  = sel ? ml2 : ml1;
  assign m_wr_en     = sel ? we2 : we1;
  assign m_wr_addr   = sel ? wa2 : wa1;
  assign m_conv_done = sel ? cd2 : cd1;
  assign m_busy      = sel ? bz2 : bz1;

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".rd_en"},     m_rd_en,     0);
    check({tag, ".rd_addr"},   m_rd_addr,   0);
    check({tag, ".mac_valid"}, m_mac_valid, 0);
    check({tag, ".mac_first"}, m_mac_first, 0);
    check({tag, ".mac_last"},  m_mac_last,  0);
    check({tag, ".wr_en"},     m_wr_en,     0);
    check({tag, ".wr_addr"},   m_wr_addr,   0);
    check({tag, ".conv_done"}, m_conv_done, 0);
    check({tag, ".busy"},      m_busy,      0);
  endtask

  // mode 0: conv_en held; 1: early res_valid in FETCH and late result;
  // 2: reset during FETCH of the 4th patch; 3: conv_en pulsed for one cycle.
  task automatic run_sweep(input int stride, input int mode, input int stall);
    int ow, nout, rd_idx, patch_rd, tap_cnt, patch_wr, cd, stall_left, wr_cyc0, last_base;
    bit res_sent, done;
    int rq[$];
    int wq[$];
    ow = (IMG - KK) / stride + 1;
    nout = ow * ow;
    for (int r = 0; r < ow; r++)
      for (int c = 0; c < ow; c++)
        for (int kr = 0; kr < KK; kr++)
          for (int kc = 0; kc < KK; kc++)
            rq.push_back((r * stride + kr) * IMG + c * stride + kc);
    for (int i = 0; i < nout; i++) wq.push_back(i);
    rd_idx = 0; patch_rd = 0; tap_cnt = 0; patch_wr = 0; cd = -1;
    stall_left = stall; wr_cyc0 = 0; last_base = -1; res_sent = 0; done = 0;
    res_valid = 0; wr_ready = 1; conv_en = 1;
    for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
      @(negedge clk);
      if (mode == 3) conv_en = 0;
      res_valid = 0;
      if (cd > 0) cd--;
      else if (cd == 0) begin res_valid = 1; res_sent = 1; cd = -1; end

      if (m_rd_en) begin
        check("rd_q_nonempty", rq.size() > 0, 1);
        if (rq.size() > 0) check("rd_addr", m_rd_addr, rq.pop_front());
        if (rd_idx == 0) last_base = int'(m_rd_addr);
        if (mode == 1 && patch_rd == 0 && rd_idx == 4) res_valid = 1;
        if (mode == 2 && patch_rd == 3 && rd_idx == 2) begin
          rst = 1;
          res_valid = 0;
          @(negedge clk);
          check_zero("rst_mid");
          rst = 0;
          return;
        end
        rd_idx++;
        if (rd_idx == KK * KK) begin rd_idx = 0; patch_rd++; end
      end

      if (m_mac_valid) begin
        check("mac_first", m_mac_first, tap_cnt == 0);
        check("mac_last",  m_mac_last,  tap_cnt == KK * KK - 1);
        if (tap_cnt == KK * KK - 1) cd = (mode == 1) ? 4 : 0;
        tap_cnt = (tap_cnt + 1) % (KK * KK);
      end else begin
        check("mac_idle", {m_mac_first, m_mac_last}, 0);
      end

      if (m_wr_en) begin
        check("res_before_wr", res_sent, 1);
        check("no_rd_in_write", m_rd_en, 0);
        check("wr_q_nonempty", wq.size() > 0, 1);
        if (wq.size() > 0) check("wr_addr", m_wr_addr, wq[0]);
        if (patch_wr == 0) wr_cyc0++;
        if (stall_left > 0) begin
          wr_ready = 0;
          stall_left--;
        end else begin
          wr_ready = 1;
          if (wq.size() > 0) wq.delete(0);
          patch_wr++;
          res_sent = 0;
          if (patch_wr == 1 && stall > 0) check("stall_hold", wr_cyc0, stall + 1);
        end
      end

      if (m_conv_done) begin
        check("done_busy", m_busy, 1);
        check("done_writes", patch_wr, nout);
        check("done_rq_empty", rq.size(), 0);
        check("last_base", last_base, 12);
        if (mode == 3) begin
          @(negedge clk);
          check("pulse_done_1cyc", m_conv_done, 0);
          check("pulse_idle_busy", m_busy, 0);
        end else begin
          repeat (3) begin
            @(negedge clk);
            check("done_held", m_conv_done, 1);
            check("no_retrigger", m_rd_en, 0);
          end
          conv_en = 0;
          @(negedge clk);
          check("done_drop", m_conv_done, 0);
          check("idle_busy", m_busy, 0);
        end
        done = 1;
      end
    end
    if (!done) check("sweep_timeout", done, 1);
    conv_en = 0;
  endtask

  initial begin
    rst = 1; conv_en = 0; res_valid = 0; wr_ready = 0; sel = 0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 0;
    @(negedge clk);

    run_sweep(1, 0, 0);   // stride 1, immediate handshakes
    @(negedge clk);
    run_sweep(1, 0, 5);   // wr_ready stall on first write
    @(negedge clk);
    run_sweep(1, 1, 0);   // res_valid during FETCH must be ignored
    @(negedge clk);
    run_sweep(1, 2, 0);   // reset mid-sweep
    run_sweep(1, 0, 0);   // restart from address 0 after reset
    @(negedge clk);
    run_sweep(1, 3, 0);   // conv_en single-cycle pulse
    @(negedge clk);
    sel = 1;
    @(negedge clk);
    run_sweep(2, 0, 0);   // stride 2: 2x2 outputs
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
